// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and stores against a word-organised RAM.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after acceptance; one request in flight.
// Backpressure: req_ready only in IDLE; the response is held stable until resp_ready.
// Optional: define DMEM_RESP_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module dmem_responder #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [1:0]            req_maskmode,
   input  logic                  req_uns,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err
);

   localparam int         DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   logic [3:0]              cnt;

   // request fields captured at acceptance
   logic                    lat_write;
   logic [ADDR_WIDTH+1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [1:0]              lat_mask;
   logic                    lat_uns;

   // word-organised storage, never reset
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // effective access fields: live inputs in IDLE (zero-wait path), latched otherwise
   logic                    in_idle;
   logic                    accept;
   logic                    enter_resp;
   logic                    acc_write;
   logic [ADDR_WIDTH+1:0]   acc_addr;
   logic [DATA_WIDTH-1:0]   acc_wdata;
   logic [1:0]              acc_mask;
   logic                    acc_uns;
   logic                    acc_err;
   logic [ADDR_WIDTH-1:0]   idx;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   byte_sh;
   logic [7:0]              sel_byte;
   logic [15:0]             sel_half;
   logic [3:0]              be;
   logic [DATA_WIDTH-1:0]   wr_lanes;
   logic [DATA_WIDTH-1:0]   ld_ext;
   logic [DATA_WIDTH-1:0]   rdata_nxt;
   logic                    do_store;

   // address bits above the storage window are deliberately ignored (wrap-around)
   logic                    unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   assign in_idle   = (state == IDLE);
   assign req_ready = in_idle;
   assign accept    = in_idle & req_valid;

   // select the fields for the access happening on the edge that enters RESP
   always_comb begin
      acc_write  = in_idle ? req_write                 : lat_write;
      acc_addr   = in_idle ? req_addr[ADDR_WIDTH+1:0]  : lat_addr;
      acc_wdata  = in_idle ? req_wdata                 : lat_wdata;
      acc_mask   = in_idle ? req_maskmode              : lat_mask;
      acc_uns    = in_idle ? req_uns                   : lat_uns;
      enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
   end

   // decode size/lane, build store lanes and the extended load value
   always_comb begin
      acc_err = (acc_mask == 2'b11);
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
      acc_err = acc_err
              | ((acc_mask == 2'b01) && acc_addr[0])
              | ((acc_mask == 2'b10) && (acc_addr[1:0] != 2'b00));
`endif
      idx      = acc_addr[ADDR_WIDTH+1:2];
      rd_word  = mem[idx];
      byte_sh  = rd_word >> {acc_addr[1:0], 3'b000};
      sel_byte = byte_sh[7:0];
      sel_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
      be       = 4'b0000;
      wr_lanes = '0;
      ld_ext   = '0;
      case (acc_mask)
         2'b00: begin
            be       = 4'b0001 << acc_addr[1:0];
            wr_lanes = {4{acc_wdata[7:0]}};
            ld_ext   = {{24{~acc_uns & sel_byte[7]}}, sel_byte};
         end
         2'b01: begin
            // low address bit is dropped: misaligned halves either error or align down
            be       = acc_addr[1] ? 4'b1100 : 4'b0011;
            wr_lanes = {2{acc_wdata[15:0]}};
            ld_ext   = {{16{~acc_uns & sel_half[15]}}, sel_half};
         end
         2'b10: begin
            be       = 4'b1111;
            wr_lanes = acc_wdata;
            ld_ext   = rd_word;
         end
         default: begin
            be       = 4'b0000;
            wr_lanes = '0;
            ld_ext   = '0;
         end
      endcase
      do_store  = rstn & enter_resp & acc_write & ~acc_err;
      rdata_nxt = (acc_write | acc_err) ? '0 : ld_ext;
   end

   // commit store lanes on the edge entering RESP
   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
         end
      end
   end

   // control FSM with registered response outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr[ADDR_WIDTH+1:0];
                  lat_wdata <= req_wdata;
                  lat_mask  <= req_maskmode;
                  lat_uns   <= req_uns;
                  if (enter_resp) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= rdata_nxt;
                     resp_err   <= acc_err;
                  end else begin
                     state <= WAIT;
                     cnt   <= WAIT_LD;
                  end
               end
            end
            WAIT: begin
               if (enter_resp) begin
                  state      <= RESP;
                  cnt        <= 4'd0;
                  resp_valid <= 1'b1;
                  resp_rdata <= rdata_nxt;
                  resp_err   <= acc_err;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder with WAIT_CYCLES=2; expected responses are queued when a
// request is driven and popped when the response appears.
// Misalignment expectations follow DMEM_RESP_MISALIGN_CHECK_EN as defined for the build.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_maskmode = 2'b00;
   logic        req_uns = 1'b0;
   logic        resp_ready = 1'b0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];

   dmem_responder #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (8),
      .WAIT_CYCLES(2)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_maskmode(req_maskmode),
      .req_uns     (req_uns),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   // drive one request, check latency and response against the scoreboard, then handshake
   task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] mm, input logic uns,
                         input logic [31:0] exp_rdata, input logic exp_err, input int hold);
      exp_t e;
      int   n;
      int   lat;
      @(negedge clk);
      req_write    = wr;
      req_addr     = addr;
      req_wdata    = wdata;
      req_maskmode = mm;
      req_uns      = uns;
      req_valid    = 1'b1;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("accept_timeout", 32'(req_ready), 32'd1);
      // accepted on the posedge just passed; scramble inputs, they must be ignored now
      @(negedge clk);
      req_valid    = 1'b0;
      req_write    = ~wr;
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_maskmode = 2'($urandom_range(0, 3));
      req_uns      = ~uns;
      chk("rdy_in_wait", 32'(req_ready), 32'd0);
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'd3);
      e = sb_q.pop_front();
      chk("rdata", resp_rdata, e.rdata);
      chk("err", 32'(resp_err), 32'(e.err));
      chk("rdy_in_resp", 32'(req_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_rdata", resp_rdata, e.rdata);
         chk("stall_err", 32'(resp_err), 32'(e.err));
         chk("stall_rdy", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("valid_clear", 32'(resp_valid), 32'd0);
      chk("rdata_clear", resp_rdata, 32'd0);
      chk("err_clear", 32'(resp_err), 32'd0);
      chk("rdy_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      int n;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_rdy", 32'(req_ready), 32'd1);

      // word store/load
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);
      // byte store, signed/unsigned byte loads, merged word
      do_req(1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, 32'h0, 1'b0, 0);
      do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 0);
      do_req(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, 0);
      // half store, signed/unsigned half loads, merged word
      do_req(1'b1, 32'h12, 32'h0000F234, 2'b01, 1'b0, 32'h0, 1'b0, 0);
      do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFFF234, 1'b0, 0);
      do_req(1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 32'h0000F234, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 0);
      // other lanes, and uns ignored on words
      do_req(1'b0, 32'h10, 32'h0, 2'b00, 1'b1, 32'h000000EF, 1'b0, 0);
      do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'hFFFFFFBE, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 32'hFFFFBEEF, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b1, 32'hF234BEEF, 1'b0, 0);
      // response held under backpressure for 5 cycles
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 5);
      // illegal size: error, no store
      do_req(1'b1, 32'h10, 32'h00000000, 2'b11, 1'b0, 32'h0, 1'b1, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 0);
      // address wraps modulo 1 KiB
      do_req(1'b0, 32'h00000410, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 0);
      do_req(1'b0, 32'hFFFFFC10, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 0);
`ifdef DMEM_RESP_MISALIGN_CHECK_EN
      do_req(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
      do_req(1'b1, 32'h11, 32'h0000AAAA, 2'b01, 1'b0, 32'h0, 1'b1, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 0);
`else
      do_req(1'b0, 32'h11, 32'h0, 2'b10, 1'b0, 32'hF234BEEF, 1'b0, 0);
      do_req(1'b1, 32'h11, 32'h0000AAAA, 2'b01, 1'b0, 32'h0, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hF234AAAA, 1'b0, 0);
`endif

      // reset in WAIT drops a pending store
      do_req(1'b1, 32'h20, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 1'b0, 0);
      @(negedge clk);
      req_write    = 1'b1;
      req_addr     = 32'h20;
      req_wdata    = 32'h12345678;
      req_maskmode = 2'b10;
      req_uns      = 1'b0;
      req_valid    = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("rw_accept_timeout", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rw_in_wait", 32'(req_ready), 32'd0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("rw_valid", 32'(resp_valid), 32'd0);
      chk("rw_rdy", 32'(req_ready), 32'd1);
      repeat (4) begin
         @(negedge clk);
         chk("rw_no_resp", 32'(resp_valid), 32'd0);
      end
      do_req(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 0);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the number of word-index bits, giving 2^ADDR_WIDTH words of storage.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, the number of extra access cycles before a response (0..15).
REQ-004 SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit, the reset: synchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1 bit, the requester presents a request.
REQ-007 SHALL have port req_ready, output, 1 bit, the responder can accept a request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32 bits, the byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits, the store data, right-aligned.
REQ-011 SHALL have port req_maskmode, input, 2 bits, the access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-012 SHALL have port req_uns, input, 1 bit, which selects zero-extension of loads when 1 and sign-extension when 0 (funct3[2]).
REQ-013 SHALL have port resp_valid, output, 1 bit, a response is present.
REQ-014 SHALL have port resp_ready, input, 1 bit, the requester accepts the response.
REQ-015 SHALL have port resp_rdata, output, 32 bits, the extended load data; 0 for stores and errors.
REQ-016 SHALL have port resp_err, output, 1 bit, the request was rejected.

Function
REQ-017 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready=1 only in IDLE, and resp_valid=1 only in RESP.
REQ-018 SHALL accept a request on the rising edge where req_valid&req_ready=1, and latch write, addr, wdata, maskmode and uns.
REQ-019 SHALL, on acceptance, go IDLE->WAIT with the counter loaded to WAIT_CYCLES, or go IDLE->RESP directly when WAIT_CYCLES=0.
REQ-020 SHALL decrement the counter in WAIT and go WAIT->RESP on the edge where the counter equals 1.
REQ-021 SHALL perform the storage access on the edge entering RESP: stores commit; load data is extended and registered into resp_rdata.
REQ-022 SHALL assert resp_valid exactly WAIT_CYCLES+1 cycles after acceptance.
REQ-023 SHALL hold resp_valid, resp_rdata and resp_err stable while resp_ready=0.
REQ-024 SHALL, on the edge where resp_valid&resp_ready=1, go RESP->IDLE and clear resp_valid, resp_rdata and resp_err.
REQ-025 SHALL NOT accept a new request in that same cycle; the earliest next acceptance is the following cycle.
REQ-026 SHALL index storage by word with addr[ADDR_WIDTH+1:2] and ignore higher address bits, so addresses wrap modulo 2^(ADDR_WIDTH+2).
REQ-027 SHALL, for a byte store, write only lane addr[1:0] with wdata[7:0].
REQ-028 SHALL, for a half store, write lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
REQ-029 SHALL, for a word store, write all four lanes.
REQ-030 SHALL, for a byte load, extract the selected byte and extend bit 7 per req_uns.
REQ-031 SHALL, for a half load, extract the selected half and extend bit 15 per req_uns.
REQ-032 SHALL ignore req_uns for word loads.
REQ-033 SHALL treat maskmode 11 as an error: resp_err=1, no store, resp_rdata=0.
REQ-034 SHALL ignore req_* inputs while not in IDLE.

Reset
REQ-035 SHALL, when rstn=0 on a rising edge, set state=IDLE, counter=0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-036 SHALL drive req_ready=1 from the first cycle after reset release.
REQ-037 SHALL, on reset mid-WAIT, discard the pending request and leave storage unmodified.
REQ-038 SHALL NOT reset storage contents.

Configuration
REQ-039 SHALL, with macro DMEM_RESP_MISALIGN_CHECK_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as an error: resp_err=1, no store, resp_rdata=0.
REQ-040 SHALL, with that macro undefined, ignore addr[0] for halves and addr[1:0] for words, so the access is aligned down and raises no error.

Verification (WAIT_CYCLES=2, DMEM_RESP_MISALIGN_CHECK_EN defined unless noted)
REQ-041 SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_rdata=0xDEADBEEF, resp_valid rises exactly 3 cycles after each acceptance, resp_err=0.
REQ-042 SHALL cover: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-043 SHALL cover: SH 0xF234 @0x12, then LH @0x12 -> 0xFFFFF234; LHU -> 0x0000F234; LW @0x10 -> 0xF234BEEF.
REQ-044 SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid=1 and resp_rdata constant, req_ready=0 throughout; IDLE one cycle after the handshake.
REQ-045 SHALL cover: LW @0x11 -> resp_err=1, resp_rdata=0; with the macro undefined -> resp_err=0 and the word at 0x10 is returned.
REQ-046 SHALL cover: SW 0x12345678 @0x20 with rstn pulsed low in WAIT -> resp_valid=0 and req_ready=1 after reset; a later LW @0x20 returns the prior contents.
